regfile_gen: RTL and testbench

Parametrised general-purpose register file for the datapath. It generalises the fixed 64-bit register array in four ways: configurable data width, configurable depth, N independent read ports, and byte-lane write enables. Register 0 is hardwired to zero. After reset, a sequencer clears the whole array, one entry per cycle, and flags the array busy until the clear is done. The block sits between decode (read addresses) and write-back (write port).

---
 rtl/regfile_gen.sv | 132 +++++++++++++
 tb/tb_regfile_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_gen.sv
// Parametrised register file: N_RD combinational read ports, byte-lane writes, r0 hardwired to zero,
// post-reset clear sweep. Define REGFILE_BYPASS_EN for same-cycle write-through forwarding to readers.
module regfile_gen #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     regwrite,
    input  logic [ADDR_W-1:0]        adr_wr_reg,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [N_RD*ADDR_W-1:0]   adr_rd,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic                     busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NBE   = DATA_W / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_idx_s;
    logic [DATA_W-1:0] mem_val_s;
    logic [DATA_W-1:0] wr_merged_s;
    logic              wr_valid_s;
    logic [ADDR_W-1:0] rd_adr_s [N_RD];

    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [NBE-1:0]    be
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int k = 0; k < NBE; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_val[8*k +: 8];
            end
        end
        return res;
    endfunction

    assign wr_merged_s = lane_merge(mem_q[adr_wr_reg], wr_data, wr_be);
    assign wr_valid_s  = regwrite && (adr_wr_reg != {ADDR_W{1'b0}});
    assign busy        = (state_q == ST_CLEAR);

    // Next-state and single array write port: clear sweep owns it in CLEAR, user in IDLE.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we_s  = 1'b0;
        mem_idx_s = adr_wr_reg;
        mem_val_s = wr_merged_s;
        if (rst) begin
            mem_we_s = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    mem_we_s  = 1'b1;
                    mem_idx_s = clr_cnt_q;
                    mem_val_s = {DATA_W{1'b0}};
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
                ST_IDLE: begin
                    state_d  = ST_IDLE;
                    mem_we_s = wr_valid_s;
                end
                default: begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= {ADDR_W{1'b0}};
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage array; not reset directly, the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_idx_s] <= mem_val_s;
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_rd_adr
        assign rd_adr_s[p] = adr_rd[p*ADDR_W +: ADDR_W];
    end

    // Read ports: zero while clearing and for r0, optional forwarding of the in-flight write.
    always_comb begin
        rd_data = {(N_RD*DATA_W){1'b0}};
        for (int p = 0; p < N_RD; p++) begin
            if ((state_q == ST_IDLE) && (rd_adr_s[p] != {ADDR_W{1'b0}})) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_valid_s && (adr_wr_reg == rd_adr_s[p])) begin
                    rd_data[p*DATA_W +: DATA_W] = wr_merged_s;
                end else begin
                    rd_data[p*DATA_W +: DATA_W] = mem_q[rd_adr_s[p]];
                end
`else
                rd_data[p*DATA_W +: DATA_W] = mem_q[rd_adr_s[p]];
`endif
            end else begin
                rd_data[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_regfile_gen.sv
// Self-checking bench for regfile_gen (default parameters) against a behavioural array model.
module tb_regfile_gen;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              regwrite = 1'b0;
    logic [AW-1:0]     adr_wr_reg = '0;
    logic [DW-1:0]     wr_data = '0;
    logic [DW/8-1:0]   wr_be = '0;
    logic [NR*AW-1:0]  adr_rd = '0;
    logic [NR*DW-1:0]  rd_data;
    logic              busy;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    int            clear_left = DEPTH;

    regfile_gen #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) dut (
        .clk(clk), .rst(rst), .regwrite(regwrite), .adr_wr_reg(adr_wr_reg),
        .wr_data(wr_data), .wr_be(wr_be), .adr_rd(adr_rd), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [7:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int k = 0; k < 8; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (clear_left > 0 || a == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (regwrite && adr_wr_reg != 5'd0 && adr_wr_reg == a)
            return merge(ref_mem[a], wr_data, wr_be);
`endif
        return ref_mem[a];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge: the model absorbs the inputs present at the edge.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else if (clear_left > 0) begin
            clear_left--;
        end else if (regwrite && adr_wr_reg != 5'd0) begin
            ref_mem[adr_wr_reg] = merge(ref_mem[adr_wr_reg], wr_data, wr_be);
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, "_busy"}, {63'd0, busy}, {63'd0, (clear_left > 0)});
        for (int p = 0; p < NR; p++)
            chk({tag, "_rd"}, rd_data[p*DW +: DW], model_rd(adr_rd[p*AW +: AW]));
    endtask

    task automatic set_wr(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [7:0] be);
        regwrite = we; adr_wr_reg = a; wr_data = d; wr_be = be;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        adr_rd = {a1, a0};
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            n++;
            check_all(tag);
            if (!busy) break;
        end
        chk({tag, "_len"}, 64'(n), 64'd32);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        // Reset for two cycles; then clear with an ignored write in flight.
        rst = 1'b1;
        cyc(); check_all("rst1");
        cyc(); check_all("rst2");
        rst = 1'b0;
        set_wr(1'b1, 5'd5, 64'hAA, 8'hFF);
        set_rd(5'd5, 5'd1);
        count_busy("clear");
        set_wr(1'b0, 5'd0, 64'd0, 8'h00);

        for (int a = 1; a < DEPTH; a++) begin
            set_rd(AW'(a), AW'(DEPTH - a));
            check_all("zero_after_clear");
            chk("zero_const", rd_data[DW-1:0], 64'd0);
        end

        // Full-width write and dual-port read.
        set_wr(1'b1, 5'd7, 64'h0123456789ABCDEF, 8'hFF);
        cyc();
        set_wr(1'b0, 5'd0, 64'd0, 8'h00);
        set_rd(5'd7, 5'd7);
        check_all("full");
        chk("full_p0", rd_data[DW-1:0], 64'h0123456789ABCDEF);
        chk("full_p1", rd_data[2*DW-1:DW], 64'h0123456789ABCDEF);

        // Byte lanes.
        set_wr(1'b1, 5'd3, 64'h1111111111111111, 8'hFF);
        cyc();
        set_wr(1'b1, 5'd3, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        cyc();
        set_wr(1'b0, 5'd0, 64'd0, 8'h00);
        set_rd(5'd3, 5'd7);
        check_all("lanes");
        chk("lanes_val", rd_data[DW-1:0], 64'h11111111FFFFFFFF);

        // Zero register, same cycle and after.
        set_wr(1'b1, 5'd0, 64'hDEADBEEF, 8'hFF);
        set_rd(5'd0, 5'd0);
        check_all("r0_same");
        chk("r0_same_val", rd_data[DW-1:0], 64'd0);
        cyc();
        set_wr(1'b0, 5'd0, 64'd0, 8'h00);
        check_all("r0_after");
        chk("r0_after_val", rd_data[2*DW-1:DW], 64'd0);

        // Bypass behaviour.
        set_wr(1'b1, 5'd9, 64'h5, 8'hFF);
        cyc();
        set_wr(1'b1, 5'd9, 64'hA, 8'hFF);
        set_rd(5'd9, 5'd3);
        check_all("byp_same");
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_val", rd_data[DW-1:0], 64'hA);
`else
        chk("byp_same_val", rd_data[DW-1:0], 64'h5);
`endif
        cyc();
        set_wr(1'b0, 5'd0, 64'd0, 8'h00);
        check_all("byp_next");
        chk("byp_next_val", rd_data[DW-1:0], 64'hA);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_wr(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                   {$urandom, $urandom}, 8'($urandom));
            if ($urandom_range(0, 3) == 0) set_rd(adr_wr_reg, AW'($urandom_range(0, DEPTH - 1)));
            else set_rd(AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)));
            check_all("rand");
            cyc();
        end

        // Reset while idle, then reset again mid-clear with a colliding write.
        set_wr(1'b1, 5'd4, 64'h77, 8'hFF);
        cyc();
        set_wr(1'b0, 5'd0, 64'd0, 8'h00);
        set_rd(5'd4, 5'd4);
        check_all("r4_set");
        chk("r4_set_val", rd_data[DW-1:0], 64'h77);
        rst = 1'b1;
        cyc(); check_all("rst_idle");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(); check_all("clr_partial");
        end
        rst = 1'b1;
        set_wr(1'b1, 5'd4, 64'h99, 8'hFF);
        cyc(); check_all("rst_mid");
        rst = 1'b0;
        set_wr(1'b0, 5'd0, 64'd0, 8'h00);
        count_busy("reclear");
        set_rd(5'd4, 5'd7);
        check_all("r4_lost");
        chk("r4_lost_val", rd_data[DW-1:0], 64'd0);
        chk("r7_lost_val", rd_data[2*DW-1:DW], 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
